// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes host words MSB-first onto a config chain; CCFF_LOADER_VERIFY_EN adds a verify pass
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);
`ifdef CCFF_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int IDX_W = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] TOTAL = VERIFY ? CNT_W'(2 * CHAIN_LEN) : LEN;
  localparam logic [IDX_W-1:0] MSB = IDX_W'(WORD_W - 1);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] bit_cnt, cnt_nx;
  logic last_bit, pass_end;
  assign cnt_nx   = bit_cnt + CNT_W'(1);
  assign last_bit = cnt_nx == TOTAL;
  assign pass_end = VERIFY && cnt_nx == LEN;
  assign in_ready = state == FETCH;
  assign busy     = state == FETCH || state == SHIFT;
  assign done     = state == DONE;
  // State register
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) state <= IDLE;
    else state <= state_nx;
  // Next state; abort overrides everything, a pass boundary forces a fresh word
  always_comb
    state_nx = abort ? IDLE
             : state == IDLE  ? (start ? FETCH : IDLE)
             : state == FETCH ? (in_valid ? SHIFT : FETCH)
             : state == SHIFT ? (last_bit ? DONE : (pass_end || bit_idx == '0) ? FETCH : SHIFT)
             : IDLE;
  // Head/shift_en are registered so each bit sits on the chain for exactly one SHIFT cycle
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) begin
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      word          <= '0;
      bit_idx       <= '0;
      bit_cnt       <= '0;
    end else begin
      ccff_shift_en <= state_nx == SHIFT;
      if (state_nx == SHIFT) ccff_head <= state == FETCH ? in_data[WORD_W-1] : word[bit_idx - IDX_W'(1)];
      if (state == FETCH && in_valid) begin
        word    <= in_data;
        bit_idx <= MSB;
      end
      if (state == IDLE && start) bit_cnt <= '0;
      if (state == SHIFT) begin
        bit_cnt <= cnt_nx;
        bit_idx <= bit_idx - IDX_W'(1);
      end
    end
`ifdef CCFF_LOADER_VERIFY_EN
  // Pass-2 bits must match the pass-1 bits emerging at the tail; a mismatch sticks until the next start
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) err <= 1'b0;
    else if (state == IDLE && start && !abort) err <= 1'b0;
    else if (ccff_shift_en && bit_cnt >= LEN && ccff_tail != ccff_head) err <= 1'b1;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of the chain loader against a 20-flop chain model
module tb_ccff_chain_loader;
  logic prog_clk = 1'b0, prog_reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, err;
  logic [19:0] chain = '0;
  logic [7:0] words [6];
  logic [63:0] sh_bits;
  logic prev_head, err_done, post_busy, post_sh, post_rdy;
  int n_sh, n_bub, n_rdy, n_done, n_stall, stall_bad, err_sh;
  int n_tests = 0, n_fail = 0;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .err(err)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[18:0], ccff_head};
  assign ccff_tail = chain[19];

  always @(negedge prog_clk) begin
    if (in_ready && !in_valid) begin
      n_stall++;
      if (ccff_shift_en || ccff_head !== prev_head) stall_bad++;
    end
    if (busy && !ccff_shift_en && n_sh > 0) n_bub++;
    if (in_ready) n_rdy++;
    if (done) begin
      n_done++;
      err_done = err;
    end
    if (err && err_sh < 0) err_sh = n_sh;
    if (ccff_shift_en) begin
      sh_bits = {sh_bits[62:0], ccff_head};
      n_sh++;
    end
    prev_head = ccff_head;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_words(input logic [7:0] a, b, c, d, e, f);
    words[0] = a; words[1] = b; words[2] = c; words[3] = d; words[4] = e; words[5] = f;
  endtask

  task automatic run(input int nw, input int stall_word, input int stall_len, input int abort_at, input int start_at);
    int i = 0, st = stall_len, cyc = 0;
    logic acc;
    sh_bits = '0; n_sh = 0; n_bub = 0; n_rdy = 0; n_done = 0;
    n_stall = 0; stall_bad = 0; err_done = 1'b0; err_sh = -1;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    while (busy && cyc < 400) begin
      in_valid = i < nw && !(i == stall_word && st > 0);
      in_data  = i < nw ? words[i] : 8'h00;
      abort    = abort_at >= 0 && n_sh == abort_at;
      start    = start_at >= 0 && n_sh == start_at;
      @(negedge prog_clk);
      acc = in_ready && in_valid;
      if (in_ready && !in_valid && st > 0) st--;
      @(posedge prog_clk); #1;
      if (acc) i++;
      cyc++;
    end
    if (cyc >= 400) check("load_timeout", busy, 1'b0);
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    post_busy = busy; post_sh = ccff_shift_en; post_rdy = in_ready;
    repeat (2) @(negedge prog_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_head", ccff_head, 0);
    check("rst_shift_en", ccff_shift_en, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (3) @(posedge prog_clk);
    #1 prog_reset = 1'b0;

`ifndef CCFF_LOADER_VERIFY_EN
    set_words(8'hA5, 8'h3C, 8'hF0, 8'h00, 8'h00, 8'h00);
    run(3, -1, 0, -1, -1);
    check("basic_bits", sh_bits, 64'hA53CF);
    check("basic_nbits", n_sh, 20);
    check("basic_bubbles", n_bub, 2);
    check("basic_ready", n_rdy, 3);
    check("basic_done", n_done, 1);
    check("basic_err", err_done, 0);

    run(3, 1, 5, -1, -1);
    check("stall_bits", sh_bits, 64'hA53CF);
    check("stall_nbits", n_sh, 20);
    check("stall_cycles", n_stall, 5);
    check("stall_quiet", stall_bad, 0);
    check("stall_done", n_done, 1);

    run(3, -1, 0, 10, -1);
    check("abort_bits", sh_bits, 64'h529);
    check("abort_nbits", n_sh, 11);
    check("abort_busy", post_busy, 0);
    check("abort_shift_en", post_sh, 0);
    check("abort_ready", post_rdy, 0);
    check("abort_no_done", n_done, 0);

    set_words(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run(3, -1, 0, -1, -1);
    check("zero_bits", sh_bits, 64'h0);
    check("zero_nbits", n_sh, 20);
    check("zero_done", n_done, 1);

    set_words(8'hA5, 8'h3C, 8'hF0, 8'h00, 8'h00, 8'h00);
    run(3, -1, 0, -1, 3);
    check("busy_start_bits", sh_bits, 64'hA53CF);
    check("busy_start_nbits", n_sh, 20);
    check("busy_start_done", n_done, 1);
`else
    set_words(8'hA5, 8'h3C, 8'hF0, 8'hA5, 8'h3C, 8'hF0);
    run(6, -1, 0, -1, -1);
    check("vfy_bits", sh_bits, 64'hA53CFA53CF);
    check("vfy_nbits", n_sh, 40);
    check("vfy_done", n_done, 1);
    check("vfy_err", err_done, 0);
    check("vfy_err_never", err_sh, 64'hFFFF_FFFF_FFFF_FFFF);

    set_words(8'hA5, 8'h3C, 8'hF0, 8'hA5, 8'h3D, 8'hF0);
    run(6, -1, 0, -1, -1);
    check("vfy_bad_bits", sh_bits, 64'hA53CFA53DF);
    check("vfy_bad_nbits", n_sh, 40);
    check("vfy_bad_done", n_done, 1);
    check("vfy_bad_err", err_done, 1);
    check("vfy_bad_err_cycle", err_sh, 36);
`endif

    set_words(8'hA5, 8'h3C, 8'hF0, 8'hA5, 8'h3C, 8'hF0);
    run(6, -1, 0, 5, 5);
    check("sa_bits", sh_bits, 64'h29);
    check("sa_busy", post_busy, 0);
    check("sa_no_done", n_done, 0);
    check("sa_stays_idle", busy, 0);

    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    repeat (4) @(posedge prog_clk);
    #1;
    check("pre_rst_shift_en", ccff_shift_en, 1);
    check("pre_rst_head", ccff_head, 1);
    #2 prog_reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_shift_en", ccff_shift_en, 0);
    check("arst_head", ccff_head, 0);
    check("arst_ready", in_ready, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    check("arst_start_ignored", busy, 0);
    @(posedge prog_clk); #1 prog_reset = 1'b0;
    @(posedge prog_clk); #1;
    check("post_rst_idle", busy, 0);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
